// File: rtl/la_capture_core_if.sv
// Control, trigger, probe and readout signals of the logic-analyzer capture core.
// master = controller/probe side, slave = capture core.
interface la_capture_core_if #(
   parameter int DATA_W = 15,
   parameter int TRIG_W = 5,
   parameter int ADDR_W = 8
);
   logic              arm_i;
   logic              abort_i;
   logic [TRIG_W-1:0] trig_mask_i;
   logic [TRIG_W-1:0] trig_value_i;
   logic              trig_edge_i;
   logic [ADDR_W-1:0] pretrig_i;
   logic [TRIG_W-1:0] trig0_i;
   logic [DATA_W-1:0] data_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [DATA_W-1:0] rd_data_o;
   logic [2:0]        state_o;
   logic              busy_o;
   logic              done_o;
   logic [ADDR_W-1:0] trig_addr_o;
   logic [ADDR_W-1:0] start_addr_o;

   modport master (
      output arm_i, abort_i, trig_mask_i, trig_value_i, trig_edge_i, pretrig_i,
             trig0_i, data_i, rd_addr_i,
      input  rd_data_o, state_o, busy_o, done_o, trig_addr_o, start_addr_o
   );

   modport slave (
      input  arm_i, abort_i, trig_mask_i, trig_value_i, trig_edge_i, pretrig_i,
             trig0_i, data_i, rd_addr_i,
      output rd_data_o, state_o, busy_o, done_o, trig_addr_o, start_addr_o
   );
endinterface

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: circular sample buffer with pre-trigger window,
// masked level/edge trigger and a frozen buffer for synchronous readout.
//
// state | meaning
// IDLE  | not capturing, buffer frozen
// PRE   | filling the pre-trigger window (pt samples)
// ARMED | writing circularly, waiting for fire
// POST  | writing the post-trigger window
// DONE  | capture complete, buffer frozen for readout
module la_capture_core #(
   parameter int DATA_W = 15,
   parameter int TRIG_W = 5,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   la_capture_core_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] wr_ptr, pre_cnt, post_cnt, pt;
   logic [ADDR_W-1:0] trig_addr, start_addr;
   logic              match, match_d, fire, capturing, we, arm_ok;

   assign match     = ((bus.trig0_i ^ bus.trig_value_i) & bus.trig_mask_i) == '0;
   assign fire      = bus.trig_edge_i ? (match & ~match_d) : match;
   assign capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
   assign we        = capturing && !bus.abort_i && !rst_i;
   assign arm_ok    = bus.arm_i && !bus.abort_i && ((state == S_IDLE) || (state == S_DONE));

   always_comb begin
      state_nxt = state;
      if (bus.abort_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (bus.arm_i) state_nxt = (bus.pretrig_i != '0) ? S_PRE : S_ARMED;
            S_PRE:          if (pre_cnt == pt - ONE) state_nxt = S_ARMED;
            S_ARMED:        if (fire) state_nxt = (pt == LAST) ? S_DONE : S_POST;
            S_POST:         if (post_cnt == ONE) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         pt         <= '0;
         trig_addr  <= '0;
         start_addr <= '0;
         match_d    <= 1'b0;
         rd_data    <= '0;
      end else begin
         state   <= state_nxt;
         match_d <= match;
         rd_data <= mem[bus.rd_addr_i];
         if (arm_ok) begin
            wr_ptr  <= '0;
            pre_cnt <= '0;
            pt      <= bus.pretrig_i;
         end
         if (we) begin
            wr_ptr <= wr_ptr + ONE;
            case (state)
               S_PRE: pre_cnt <= pre_cnt + ONE;
               S_ARMED: begin
                  // Trigger sample is the one being written this cycle
                  if (fire) begin
                     trig_addr  <= wr_ptr;
                     start_addr <= wr_ptr - pt;
                     post_cnt   <= LAST - pt;
                  end
               end
               S_POST: post_cnt <= post_cnt - ONE;
               default: ;
            endcase
         end
      end
   end

   // Buffer storage carries no reset so it maps onto block RAM
   always_ff @(posedge clk_i) begin
      if (we) mem[wr_ptr] <= bus.data_i;
   end

   assign bus.rd_data_o    = rd_data;
   assign bus.state_o      = state;
   assign bus.busy_o       = capturing;
   assign bus.done_o       = (state == S_DONE);
   assign bus.trig_addr_o  = trig_addr;
   assign bus.start_addr_o = start_addr;
endmodule
